// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller:
// coin codes (5-cent units), FSM state encoding and coin value decode.
package vend_pkg;

  localparam int unsigned COIN_W = 3;

  localparam logic [COIN_W-1:0] NICKEL      = 3'd1;
  localparam logic [COIN_W-1:0] DIME        = 3'd2;
  localparam logic [COIN_W-1:0] NICKEL_DIME = 3'd3;
  localparam logic [COIN_W-1:0] DIME_DIME   = 3'd4;
  localparam logic [COIN_W-1:0] QUARTER     = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3
  } state_e;

  // Value in 5-cent units; the code is its own value, invalid codes give 0.
  function automatic logic [COIN_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    case (code)
      NICKEL, DIME, NICKEL_DIME, DIME_DIME, QUARTER: coin_value = code;
      default:                                       coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change selector: picks the largest hopper coin (QUARTER, DIME,
// NICKEL) not exceeding the remaining credit.
// Ports: remaining (credit still owed), coin_c (coin code to pay out this
// cycle, 0 when nothing owed), amount_c (units to subtract from credit).
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] remaining,
  output logic [COIN_W-1:0]   coin_c,
  output logic [CREDIT_W-1:0] amount_c
);

  always_comb begin
    coin_c   = '0;
    amount_c = '0;
    if (remaining >= CREDIT_W'(5)) begin
      coin_c   = QUARTER;
      amount_c = CREDIT_W'(5);
    end else if (remaining >= CREDIT_W'(2)) begin
      coin_c   = DIME;
      amount_c = CREDIT_W'(2);
    end else if (remaining != '0) begin
      coin_c   = NICKEL;
      amount_c = CREDIT_W'(1);
    end
  end

endmodule

// File: rtl/vend_multi_fsm.sv
// Multi-item vending controller: credit accumulation up to a cap, per-item
// prices and stock, cancel/refund and serial greedy change payout.
// Ports: clock/reset (sync, active-high); coin, select_valid/select, cancel,
// restock inputs; registered vend/vend_item, state, credit, coin_out,
// coin_reject, sel_reject; sold_out decoded from the stock registers.
// Build option: VEND_TIMEOUT_EN adds an idle counter that auto-refunds
// credit after TIMEOUT_CYC idle CREDIT cycles.
module vend_multi_fsm
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned MAX_CREDIT  = 40,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICE = {6'd10, 6'd7, 6'd3, 6'd5},
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned ITEM_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [COIN_W-1:0]    coin,
  input  logic                 select_valid,
  input  logic [ITEM_W-1:0]    select,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 vend,
  output logic [ITEM_W-1:0]    vend_item,
  output logic [2:0]           state,
  output logic [CREDIT_W-1:0]  credit,
  output logic [COIN_W-1:0]    coin_out,
  output logic                 coin_reject,
  output logic                 sel_reject,
  output logic [NUM_ITEMS-1:0] sold_out
);

  // Elaboration-time parameter sanity.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("vend_multi_fsm: TIMEOUT_CYC must be at least 1");
  end
  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_cap
    $error("vend_multi_fsm: MAX_CREDIT must fit in CREDIT_W bits");
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                vend_d, coin_reject_d, sel_reject_d;
  logic [ITEM_W-1:0]   vend_item_d;
  logic [COIN_W-1:0]   coin_out_d;

  logic [COIN_W-1:0]   coin_val_c, coin_add_c, chg_coin_c;
  logic [CREDIT_W:0]   coin_sum_c;
  logic                coin_ok_c, item_ok_c, item_sold_c, timeout_c;
  logic [CREDIT_W-1:0] price_c, chg_amt_c;

  vend_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .remaining (credit),
    .coin_c    (chg_coin_c),
    .amount_c  (chg_amt_c)
  );

  // Stock-empty flags straight from the stock registers.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  // Coin acceptance: sum is one bit wider so the cap compare cannot wrap.
  always_comb begin
    coin_val_c = coin_value(coin);
    coin_sum_c = {1'b0, credit} + (CREDIT_W+1)'(coin_val_c);
    coin_ok_c  = (coin_val_c != '0) && (coin_sum_c <= (CREDIT_W+1)'(MAX_CREDIT));
    coin_add_c = coin_ok_c ? coin_val_c : '0;
  end

  // Price and stock lookup for the requested item.
  always_comb begin
    price_c     = '0;
    item_sold_c = 1'b0;
    item_ok_c   = (32'(select) < NUM_ITEMS);
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (select == ITEM_W'(i)) begin
        price_c     = ITEM_PRICE[i*CREDIT_W +: CREDIT_W];
        item_sold_c = sold_out[i];
      end
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle CREDIT cycles; the last idle cycle triggers the refund.
  always_comb begin
    tmo_d = '0;
    if (state_q == CREDIT && !(coin_ok_c || select_valid)) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign timeout_c = (state_q == CREDIT) && !(coin_ok_c || select_valid) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  // Without the timeout, credit is held until select or cancel.
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit;
    stock_d       = stock_q;
    vend_d        = 1'b0;
    vend_item_d   = '0;
    coin_out_d    = '0;
    coin_reject_d = 1'b0;
    sel_reject_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (restock) begin
          for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end
        if (coin_ok_c) begin
          credit_d = credit + CREDIT_W'(coin_add_c);
          state_d  = CREDIT;
        end else if (coin != '0) begin
          coin_reject_d = 1'b1;
        end
      end

      CREDIT: begin
        if (cancel || timeout_c) begin
          state_d       = CHANGE;
          coin_reject_d = (coin != '0);
        end else begin
          coin_reject_d = (coin != '0) && !coin_ok_c;
          credit_d      = credit + CREDIT_W'(coin_add_c);
          if (select_valid) begin
            // Affordability is judged on credit before this cycle's coin.
            if (!item_ok_c || item_sold_c || (credit < price_c)) begin
              sel_reject_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                if (select == ITEM_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
              end
              credit_d    = credit + CREDIT_W'(coin_add_c) - price_c;
              vend_d      = 1'b1;
              vend_item_d = select;
              state_d     = VEND;
            end
          end
        end
      end

      VEND: begin
        coin_reject_d = (coin != '0);
        state_d       = (credit != '0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        coin_reject_d = (coin != '0);
        if (credit == '0) begin
          state_d = IDLE;
        end else begin
          coin_out_d = chg_coin_c;
          credit_d   = credit - chg_amt_c;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any owed credit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      coin_out    <= '0;
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      vend        <= vend_d;
      vend_item   <= vend_item_d;
      coin_out    <= coin_out_d;
      coin_reject <= coin_reject_d;
      sel_reject  <= sel_reject_d;
      stock_q     <= stock_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vend_multi_fsm.sv
// Directed self-checking bench for vend_multi_fsm (prices 5/3/7/10,
// stock depth 2 so sell-out is reachable quickly).
module tb_vend_multi_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] coin = '0;
  logic       select_valid = 1'b0;
  logic [1:0] select = '0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       vend;
  logic [1:0] vend_item;
  logic [2:0] state;
  logic [5:0] credit;
  logic [2:0] coin_out;
  logic       coin_reject;
  logic       sel_reject;
  logic [3:0] sold_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  vend_multi_fsm #(
    .STOCK_INIT (2)
`ifdef VEND_TIMEOUT_EN
    , .TIMEOUT_CYC (4)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .coin         (coin),
    .select_valid (select_valid),
    .select       (select),
    .cancel       (cancel),
    .restock      (restock),
    .vend         (vend),
    .vend_item    (vend_item),
    .state        (state),
    .credit       (credit),
    .coin_out     (coin_out),
    .coin_reject  (coin_reject),
    .sel_reject   (sel_reject),
    .sold_out     (sold_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus (set at negedge, sampled at posedge), then idle inputs.
  task automatic drive(input logic [2:0] c, input logic sv, input logic [1:0] sl,
                       input logic cn, input logic rs);
    coin = c; select_valid = sv; select = sl; cancel = cn; restock = rs;
    @(negedge clock);
    coin = '0; select_valid = 1'b0; select = '0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic idle();
    drive(3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_state", 32'(state), 0);
    check("rst_credit", 32'(credit), 0);
    check("rst_vend", 32'(vend), 0);
    check("rst_coin_out", 32'(coin_out), 0);
    check("rst_sold_out", 32'(sold_out), 0);
    reset = 1'b0;

    // Exact-price purchase of item0 with a quarter
    drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("q_state", 32'(state), 1);
    check("q_credit", 32'(credit), 5);
    drive(3'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("s0_vend", 32'(vend), 1);
    check("s0_item", 32'(vend_item), 0);
    check("s0_credit", 32'(credit), 0);
    check("s0_state", 32'(state), 2);
    idle();
    check("s0_idle", 32'(state), 0);
    check("s0_vend_off", 32'(vend), 0);
    check("s0_coin_out", 32'(coin_out), 0);

    // Credit 8, buy item1 (price 3), one quarter back
    do_reset();
    drive(3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("c8_credit", 32'(credit), 8);
    drive(3'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    check("s1_vend", 32'(vend), 1);
    check("s1_item", 32'(vend_item), 1);
    check("s1_credit", 32'(credit), 5);
    idle();
    check("s1_change", 32'(state), 3);
    check("s1_co0", 32'(coin_out), 0);
    idle();
    check("s1_co5", 32'(coin_out), 5);
    check("s1_cr0", 32'(credit), 0);
    idle();
    check("s1_idle", 32'(state), 0);
    check("s1_co_off", 32'(coin_out), 0);

    // Unaffordable item2, then cancel; coin during CHANGE rejected
    do_reset();
    drive(3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(3'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    check("s2_rej", 32'(sel_reject), 1);
    check("s2_credit", 32'(credit), 2);
    check("s2_state", 32'(state), 1);
    drive(3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("can_state", 32'(state), 3);
    check("can_rej_off", 32'(sel_reject), 0);
    drive(3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("can_co2", 32'(coin_out), 2);
    check("can_coin_rej", 32'(coin_reject), 1);
    check("can_cr0", 32'(credit), 0);
    idle();
    check("can_idle", 32'(state), 0);

    // Sell out item0 (stock 2), refused third buy, restock
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
      drive(3'd0, 1'b1, 2'd0, 1'b0, 1'b0);
      check("so_vend", 32'(vend), 1);
      idle();
    end
    check("so_flag", 32'(sold_out), 4'b0001);
    drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(3'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    check("so_rej", 32'(sel_reject), 1);
    check("so_vend_off", 32'(vend), 0);
    check("so_credit", 32'(credit), 5);
    drive(3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    check("so_refund", 32'(coin_out), 5);
    idle();
    check("so_idle", 32'(state), 0);
    drive(3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    check("restock", 32'(sold_out), 0);

    // Invalid code and credit cap
    do_reset();
    drive(3'd6, 1'b0, 2'd0, 1'b0, 1'b0);
    check("inv_rej", 32'(coin_reject), 1);
    check("inv_credit", 32'(credit), 0);
    check("inv_state", 32'(state), 0);
    for (int k = 0; k < 8; k++) drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("cap_credit", 32'(credit), 40);
    check("cap_acc", 32'(coin_reject), 0);
    drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    check("cap_rej", 32'(coin_reject), 1);
    check("cap_hold", 32'(credit), 40);
    drive(3'd7, 1'b0, 2'd0, 1'b0, 1'b0);
    check("inv7_rej", 32'(coin_reject), 1);

    // Reset in the first CHANGE cycle forfeits credit
    do_reset();
    drive(3'd5, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
    check("c9_credit", 32'(credit), 9);
    drive(3'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    check("c9_change", 32'(state), 3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_credit", 32'(credit), 0);
    check("mid_rst_co", 32'(coin_out), 0);
    check("mid_rst_state", 32'(state), 0);

`ifdef VEND_TIMEOUT_EN
    // Idle credit is refunded after four CREDIT cycles
    do_reset();
    drive(3'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("tmo_hold", 32'(state), 1);
    end
    idle();
    check("tmo_change", 32'(state), 3);
    idle();
    check("tmo_co2", 32'(coin_out), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
